cache_set_assoc: RTL and testbench



---
 rtl/cache_pkg.sv | 33 +++
 rtl/cache_way.sv | 53 +++++
 rtl/cache_set_assoc.sv | 164 ++++++++++++++++
 tb/tb_cache_set_assoc.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache set: op encodings,
// a constant-foldable clog2 and the LRU age update rule.
package cache_pkg;

  // {comp, write} request encodings
  localparam logic [1:0] OP_ACC_RD = 2'b00;
  localparam logic [1:0] OP_FILL   = 2'b01;
  localparam logic [1:0] OP_CMP_RD = 2'b10;
  localparam logic [1:0] OP_CMP_WR = 2'b11;

  // Ages are passed through the helper at this fixed width, callers truncate
  localparam int AGE_MAX_W = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // New age of one way when way with age age_hit is touched
  function automatic logic [AGE_MAX_W-1:0] age_next(
    input logic [AGE_MAX_W-1:0] age,
    input logic [AGE_MAX_W-1:0] age_hit,
    input logic                 is_hit
  );
    if (is_hit) return '0;
    if (age < age_hit) return age + 1'b1;
    return age;
  endfunction

endpackage

// File: rtl/cache_way.sv
// One way of a cache set: tag/valid/dirty and a word array with
// per-word write and asynchronous word read.
module cache_way
  import cache_pkg::*;
#(
  parameter int WORDS  = 4,
  parameter int TAG_W  = 5,
  parameter int DATA_W = 16,
  parameter int WRD_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              fill,
  input  logic              mark_dirty,
  input  logic [WRD_W-1:0]  word,
  input  logic [DATA_W-1:0] wdata,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic              valid_in,
  output logic [TAG_W-1:0]  tag,
  output logic              valid,
  output logic              dirty,
  output logic [DATA_W-1:0] rdata
);

  logic [WORDS-1:0][DATA_W-1:0] mem;

  // Status bits: only these are reset, fill clears dirty
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dirty <= 1'b0;
    end else if (fill) begin
      valid <= valid_in;
      dirty <= 1'b0;
    end else if (mark_dirty) begin
      dirty <= 1'b1;
    end
  end

  // Tag is loaded on fill only; no reset needed since valid guards it
  always_ff @(posedge clk) begin
    if (fill) tag <= tag_in;
  end

  // Word array write
  always_ff @(posedge clk) begin
    if (wr_en) mem[word] <= wdata;
  end

  assign rdata = mem[word];

endmodule

// File: rtl/cache_set_assoc.sv
// One index of an N-way set-associative cache: tag compare, true-LRU
// victim choice and registered response per request.
module cache_set_assoc
  import cache_pkg::*;
#(
  parameter  int WAYS   = 4,
  parameter  int WORDS  = 4,
  parameter  int TAG_W  = 5,
  parameter  int DATA_W = 16,
  localparam int WAY_W  = (clog2(WAYS) > 0) ? clog2(WAYS) : 1,
  localparam int WRD_W  = (clog2(WORDS) > 0) ? clog2(WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              comp,
  input  logic              write,
  input  logic [WRD_W-1:0]  word,
  input  logic [WAY_W-1:0]  way_in,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              done,
  output logic              hit,
  output logic [WAY_W-1:0]  hit_way,
  output logic [DATA_W-1:0] data_out,
  output logic [TAG_W-1:0]  tag_out,
  output logic              valid_out,
  output logic              dirty_out
);

  logic [WAYS-1:0][TAG_W-1:0]  w_tag;
  logic [WAYS-1:0][DATA_W-1:0] w_rdata;
  logic [WAYS-1:0]             w_valid, w_dirty;
  logic [WAYS-1:0]             wr_en, fill, mark_dirty;
  logic [WAYS-1:0][WAY_W-1:0]  age, age_n;

  logic             req, hit_any, inv_any, touch;
  logic [1:0]       op;
  logic [WAY_W-1:0] hit_idx, inv_idx, lru_idx, victim, sel, touch_idx;
  logic [AGE_MAX_W-1:0] nx;

  assign req = enable && !rst;
  assign op  = {comp, write};

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    cache_way #(.WORDS(WORDS), .TAG_W(TAG_W), .DATA_W(DATA_W), .WRD_W(WRD_W)) u_way (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en[g]),
      .fill       (fill[g]),
      .mark_dirty (mark_dirty[g]),
      .word       (word),
      .wdata      (data_in),
      .tag_in     (tag_in),
      .valid_in   (valid_in),
      .tag        (w_tag[g]),
      .valid      (w_valid[g]),
      .dirty      (w_dirty[g]),
      .rdata      (w_rdata[g])
    );
  end

  // Tag match and victim search; descending scans so the lowest index wins
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    inv_any = 1'b0;
    inv_idx = '0;
    lru_idx = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_valid[w] && w_tag[w] == tag_in) begin
        hit_any = 1'b1;
        hit_idx = WAY_W'(w);
      end
      if (!w_valid[w]) begin
        inv_any = 1'b1;
        inv_idx = WAY_W'(w);
      end
      if (age[w] == WAY_W'(WAYS - 1)) lru_idx = WAY_W'(w);
    end
    victim = inv_any ? inv_idx : lru_idx;
  end

  // Reported way, LRU touch target and per-way write strobes
  always_comb begin
    sel        = way_in;
    touch      = 1'b0;
    touch_idx  = way_in;
    wr_en      = '0;
    fill       = '0;
    mark_dirty = '0;
    case (op)
      OP_CMP_RD, OP_CMP_WR: begin
        sel       = hit_any ? hit_idx : victim;
        touch     = hit_any;
        touch_idx = hit_idx;
      end
      OP_FILL: touch = 1'b1;
      default: ;
    endcase
    if (req) begin
      if (op == OP_CMP_WR && hit_any) begin
        wr_en[hit_idx]      = 1'b1;
        mark_dirty[hit_idx] = 1'b1;
      end
      if (op == OP_FILL) begin
        wr_en[way_in] = 1'b1;
        fill[way_in]  = 1'b1;
      end
    end
  end

  // Ages after touching touch_idx
  always_comb begin
    age_n = age;
    nx    = '0;
    for (int w = 0; w < WAYS; w++) begin
      nx = age_next(AGE_MAX_W'(age[w]), AGE_MAX_W'(age[touch_idx]),
                    touch_idx == WAY_W'(w));
      age_n[w] = nx[WAY_W-1:0];
    end
  end

  // LRU age registers, reset to age[w]=w
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++) age[w] <= WAY_W'(w);
    end else if (req && touch) begin
      age <= age_n;
    end
  end

  // Registered response; outputs hold when idle, fill reports post-fill state
  always_ff @(posedge clk) begin
    if (rst) begin
      done      <= 1'b0;
      hit       <= 1'b0;
      hit_way   <= '0;
      data_out  <= '0;
      tag_out   <= '0;
      valid_out <= 1'b0;
      dirty_out <= 1'b0;
    end else begin
      done <= enable;
      if (enable) begin
        hit     <= comp && hit_any;
        hit_way <= sel;
        if (op == OP_FILL) begin
          data_out  <= data_in;
          tag_out   <= tag_in;
          valid_out <= valid_in;
          dirty_out <= 1'b0;
        end else begin
          data_out  <= (op == OP_CMP_WR && hit_any) ? data_in : w_rdata[sel];
          tag_out   <= w_tag[sel];
          valid_out <= w_valid[sel];
          dirty_out <= w_dirty[sel];
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_set_assoc.sv
// Bench for cache_set_assoc: directed scenarios plus random traffic, checked
// against a recency-list model of the cache set.
module tb_cache_set_assoc;

  localparam int WAYS = 4, WORDS = 4, TAG_W = 5, DATA_W = 16;
  localparam int WAY_W = 2, WRD_W = 2;

  logic              clk = 1'b0;
  logic              rst, enable, comp, write, valid_in;
  logic [WRD_W-1:0]  word;
  logic [WAY_W-1:0]  way_in;
  logic [TAG_W-1:0]  tag_in;
  logic [DATA_W-1:0] data_in;
  logic              done, hit, valid_out, dirty_out;
  logic [WAY_W-1:0]  hit_way;
  logic [DATA_W-1:0] data_out;
  logic [TAG_W-1:0]  tag_out;

  int total = 0, bad = 0;

  cache_set_assoc #(.WAYS(WAYS), .WORDS(WORDS), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .comp(comp), .write(write),
    .word(word), .way_in(way_in), .tag_in(tag_in), .data_in(data_in),
    .valid_in(valid_in), .done(done), .hit(hit), .hit_way(hit_way),
    .data_out(data_out), .tag_out(tag_out), .valid_out(valid_out),
    .dirty_out(dirty_out)
  );

  always #5 clk = ~clk;

  // Model: plain arrays plus a recency list (front = most recently used)
  logic [TAG_W-1:0]  m_tag [WAYS];
  bit                m_val [WAYS], m_dirty [WAYS], m_tk [WAYS];
  logic [DATA_W-1:0] m_data [WAYS][WORDS];
  bit                m_dk [WAYS][WORDS];
  int                rec[$];

  bit                e_hit, e_valid, e_dirty, e_dk, e_tk;
  int                e_way;
  logic [DATA_W-1:0] e_data;
  logic [TAG_W-1:0]  e_tag;

  function automatic void model_touch(int w);
    foreach (rec[i]) if (rec[i] == w) begin rec.delete(i); break; end
    rec.push_front(w);
  endfunction

  function automatic void model_reset();
    rec.delete();
    for (int w = 0; w < WAYS; w++) begin
      m_val[w] = 0; m_dirty[w] = 0; rec.push_back(w);
    end
    e_hit = 0; e_way = 0; e_data = '0; e_tag = '0; e_valid = 0; e_dirty = 0;
    e_dk = 1; e_tk = 1;
  endfunction

  function automatic void model_report(int w, int wd);
    e_way = w; e_tag = m_tag[w]; e_tk = m_tk[w]; e_valid = m_val[w];
    e_dirty = m_dirty[w]; e_data = m_data[w][wd]; e_dk = m_dk[w][wd];
  endfunction

  function automatic void model_req(bit c, bit wr, int wd, int wy,
                                    logic [TAG_W-1:0] tg, logic [DATA_W-1:0] d, bit v);
    int hw, vic;
    hw = -1; vic = -1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (m_val[w] && m_tag[w] == tg) hw = w;
      if (!m_val[w]) vic = w;
    end
    if (vic < 0) vic = rec[rec.size() - 1];
    e_hit = 0;
    if (c) begin
      if (hw >= 0) begin
        e_hit = 1;
        model_report(hw, wd);
        if (wr) begin
          e_data = d; e_dk = 1;
          m_data[hw][wd] = d; m_dk[hw][wd] = 1; m_dirty[hw] = 1;
        end
        model_touch(hw);
      end else begin
        model_report(vic, wd);
      end
    end else if (!wr) begin
      model_report(wy, wd);
    end else begin
      m_data[wy][wd] = d; m_dk[wy][wd] = 1;
      m_tag[wy] = tg; m_tk[wy] = 1; m_val[wy] = v; m_dirty[wy] = 0;
      model_report(wy, wd);
      model_touch(wy);
    end
  endfunction

  // Drive one request at negedge; returns 1 ns after the sampling edge
  task automatic do_req(bit c, bit wr, int wd, int wy,
                        logic [TAG_W-1:0] tg, logic [DATA_W-1:0] d, bit v);
    @(negedge clk);
    enable = 1; comp = c; write = wr; word = WRD_W'(wd); way_in = WAY_W'(wy);
    tag_in = tg; data_in = d; valid_in = v;
    model_req(c, wr, wd, wy, tg, d, v);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    enable = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; enable = 0; comp = 0; write = 0; word = '0; way_in = '0;
    tag_in = '0; data_in = '0; valid_in = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if ({hit, hit_way, data_out, tag_out, valid_out, dirty_out} !== '0) begin
      bad++; $display("FAIL reset_outs got=%b/%0d/%h/%h/%b/%b exp=all zero",
                      hit, hit_way, data_out, tag_out, valid_out, dirty_out);
    end
    @(negedge clk); rst = 0;
    do_req(1, 0, 0, 0, 5'h03, '0, 0);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL first_done got=%b exp=1", done); end
    total++; if (hit !== 1'b0 || hit_way !== 2'd0 || valid_out !== 1'b0) begin
      bad++; $display("FAIL first_miss got hit=%b way=%0d valid=%b exp 0/0/0", hit, hit_way, valid_out);
    end
  endtask

  task automatic test_fill_hit();
    do_req(0, 1, 1, 2, 5'h0A, 16'hBEEF, 1);
    total++; if (hit !== 1'b0 || tag_out !== 5'h0A || valid_out !== 1'b1 || dirty_out !== 1'b0) begin
      bad++; $display("FAIL fill_resp got hit=%b tag=%h v=%b d=%b exp 0/0a/1/0", hit, tag_out, valid_out, dirty_out);
    end
    do_req(1, 0, 1, 0, 5'h0A, '0, 0);
    total++; if (hit !== 1'b1 || hit_way !== 2'd2) begin
      bad++; $display("FAIL fill_hit got hit=%b way=%0d exp 1/2", hit, hit_way);
    end
    total++; if (data_out !== 16'hBEEF || dirty_out !== 1'b0) begin
      bad++; $display("FAIL fill_data got data=%h dirty=%b exp beef/0", data_out, dirty_out);
    end
  endtask

  task automatic test_cmp_write();
    do_req(1, 1, 1, 0, 5'h0A, 16'h1234, 0);
    total++; if (hit !== 1'b1 || dirty_out !== 1'b0 || data_out !== 16'h1234) begin
      bad++; $display("FAIL cwr_resp got hit=%b dirty=%b data=%h exp 1/0/1234", hit, dirty_out, data_out);
    end
    do_req(1, 0, 1, 0, 5'h0A, '0, 0);
    total++; if (data_out !== 16'h1234 || dirty_out !== 1'b1) begin
      bad++; $display("FAIL raw_read got data=%h dirty=%b exp 1234/1", data_out, dirty_out);
    end
  endtask

  task automatic test_victim();
    for (int w = 0; w < WAYS; w++)
      do_req(0, 1, 0, w, TAG_W'(w + 1), DATA_W'($urandom), 1);
    do_req(1, 0, 0, 0, 5'h01, '0, 0);
    total++; if (hit !== 1'b1 || hit_way !== 2'd0) begin
      bad++; $display("FAIL victim_pre got hit=%b way=%0d exp 1/0", hit, hit_way);
    end
    do_req(1, 0, 0, 0, 5'h09, '0, 0);
    total++; if (hit !== 1'b0 || hit_way !== 2'd1 || tag_out !== 5'h02 || valid_out !== 1'b1) begin
      bad++; $display("FAIL victim_miss got hit=%b way=%0d tag=%h v=%b exp 0/1/02/1",
                      hit, hit_way, tag_out, valid_out);
    end
    idle_cycle();
    total++; if (done !== 1'b0 || hit_way !== 2'd1 || tag_out !== 5'h02 || valid_out !== 1'b1) begin
      bad++; $display("FAIL idle_hold got done=%b way=%0d tag=%h v=%b exp 0/1/02/1",
                      done, hit_way, tag_out, valid_out);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    logic [TAG_W-1:0] tg;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tg = (i % 2 == 0) ? TAG_W'($urandom_range(1, 4)) : TAG_W'($urandom_range(9, 15));
      do_req(1, (i % 4 == 0), $urandom_range(0, WORDS - 1), 0, tg, DATA_W'($urandom), 0);
      if (done === 1'b1) pulses++;
      total++; if (hit !== e_hit || hit_way !== WAY_W'(e_way)) begin
        bad++; $display("FAIL b2b_%0d_hit got hit=%b way=%0d exp %b/%0d", i, hit, hit_way, e_hit, e_way);
      end
      total++; if ((e_dk && data_out !== e_data) || (e_tk && tag_out !== e_tag) ||
                   valid_out !== e_valid || dirty_out !== e_dirty) begin
        bad++; $display("FAIL b2b_%0d_data got %h/%h/%b/%b exp %h/%h/%b/%b", i,
                        data_out, tag_out, valid_out, dirty_out, e_data, e_tag, e_valid, e_dirty);
      end
    end
    idle_cycle();
    total++; if (pulses != 8 || done !== 1'b0) begin
      bad++; $display("FAIL b2b_pulses got=%0d done_after=%b exp 8/0", pulses, done);
    end
  endtask

  task automatic test_reset_inflight();
    do_req(0, 1, 0, 0, 5'h11, 16'hA5A5, 1);
    @(negedge clk);
    rst = 1; enable = 1; comp = 1; write = 0; tag_in = 5'h11;
    @(posedge clk);
    #1;
    model_reset();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_inflight_done got=%b exp=0", done); end
    @(negedge clk); rst = 0; enable = 0;
    do_req(1, 0, 0, 0, 5'h11, '0, 0);
    total++; if (hit !== 1'b0 || hit_way !== 2'd0 || valid_out !== 1'b0) begin
      bad++; $display("FAIL rst_inflight_miss got hit=%b way=%0d v=%b exp 0/0/0", hit, hit_way, valid_out);
    end
  endtask

  task automatic test_random();
    int op;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        idle_cycle();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rnd_%0d_idle got=%b exp=0", i, done); end
        continue;
      end
      op = $urandom_range(0, 3);
      do_req(op[1], op[0], $urandom_range(0, WORDS - 1), $urandom_range(0, WAYS - 1),
             TAG_W'($urandom_range(0, 5)), DATA_W'($urandom), ($urandom_range(0, 7) != 0));
      total++; if (done !== 1'b1 || hit !== e_hit || hit_way !== WAY_W'(e_way)) begin
        bad++; $display("FAIL rnd_%0d_hit op=%0d got done=%b hit=%b way=%0d exp 1/%b/%0d",
                        i, op, done, hit, hit_way, e_hit, e_way);
      end
      total++; if ((e_dk && data_out !== e_data) || (e_tk && tag_out !== e_tag) ||
                   valid_out !== e_valid || dirty_out !== e_dirty) begin
        bad++; $display("FAIL rnd_%0d_data op=%0d got %h/%h/%b/%b exp %h/%h/%b/%b", i, op,
                        data_out, tag_out, valid_out, dirty_out, e_data, e_tag, e_valid, e_dirty);
      end
    end
  endtask

  initial begin
    for (int w = 0; w < WAYS; w++) begin
      m_tk[w] = 0;
      for (int k = 0; k < WORDS; k++) m_dk[w][k] = 0;
    end
    test_reset();
    test_fill_hit();
    test_cmp_write();
    test_victim();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
